// File: rtl/layer_pass_sequencer_pkg.sv
// layer_pass_sequencer_pkg: sequencer states and mapping_param field layout shared with the pass controller
package layer_pass_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, ADVANCE, DONE} seq_state_e;
  localparam int E_LSB = 12;
  localparam int E_W = 5;
  localparam int P_LSB = 9;
  localparam int P_W = 3;
  localparam int Q_LSB = 6;
  localparam int Q_W = 3;
  localparam int R_LSB = 3;
  localparam int R_W = 3;
  localparam int T_LSB = 0;
  localparam int T_W = 3;
  function automatic logic [5:0] field_prod(input logic [2:0] a, input logic [2:0] b);
    return {3'b0, a} * {3'b0, b};
  endfunction
endpackage

// File: rtl/layer_pass_sequencer_seq_addr_accum.sv
// seq_addr_accum: address register that reloads its base or advances by a stride, wrapping modulo 2^ADDR_W
module seq_addr_accum #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr
);
  always_ff @(posedge clk or posedge rst)
    if (rst) addr <= '0;
    else if (load) addr <= base;
    else if (step) addr <= addr + stride;
endmodule

// File: rtl/layer_pass_sequencer.sv
// layer_pass_sequencer: splits a layer into output-group x input-group passes and drives the pass controller
module layer_pass_sequencer
  import layer_pass_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 layer_start,
  input  logic [31:0]          layer_op_config,
  input  logic [31:0]          layer_mapping_param,
  input  logic [31:0]          layer_shape_param1,
  input  logic [31:0]          layer_shape_param2,
  input  logic [CNT_W-1:0]     layer_M,
  input  logic [CNT_W-1:0]     layer_C,
  input  logic [ADDR_W-1:0]    filter_base,
  input  logic [ADDR_W-1:0]    ifmap_base,
  input  logic [ADDR_W-1:0]    bias_base,
  input  logic [ADDR_W-1:0]    opsum_base,
  input  logic [ADDR_W-1:0]    filter_pass_stride,
  input  logic [ADDR_W-1:0]    ifmap_cgrp_stride,
  input  logic [ADDR_W-1:0]    bias_mgrp_stride,
  input  logic [ADDR_W-1:0]    opsum_mgrp_stride,
  input  logic                 pass_done,
  output logic                 pass_start,
  output logic [31:0]          pass_op_config,
  output logic [31:0]          pass_mapping_param,
  output logic [31:0]          pass_shape_param1,
  output logic [31:0]          pass_shape_param2,
  output logic                 pass_bias_ipsum_sel,
  output logic [ADDR_W-1:0]    pass_filter_baseaddr,
  output logic [ADDR_W-1:0]    pass_ifmap_baseaddr,
  output logic [ADDR_W-1:0]    pass_bias_baseaddr,
  output logic [ADDR_W-1:0]    pass_opsum_baseaddr,
  output logic                 busy,
  output logic                 layer_done,
  output logic [2*CNT_W-1:0]   pass_idx
);
  seq_state_e state, state_nx;
  logic [31:1] op_q;
  logic [31:0] map_q, sh1_q, sh2_q;
  logic [CNT_W-1:0] m_q, c_q, m_ct, c_ct;
  logic [CNT_W:0] m_acc, c_acc;
  logic [ADDR_W-1:0] fb_q, ib_q, bb_q, ob_q, fs_q, is_q, bs_q, os_q;
  logic [5:0] pt, qr;
  logic accept, load, adv, c_more, m_more;
  assign pt = field_prod(map_q[P_LSB +: P_W], map_q[T_LSB +: T_W]);
  assign qr = field_prod(map_q[Q_LSB +: Q_W], map_q[R_LSB +: R_W]);
  assign c_more = (c_acc + {{(CNT_W-5){1'b0}}, qr}) < {1'b0, c_q};
  assign m_more = (m_acc + {{(CNT_W-5){1'b0}}, pt}) < {1'b0, m_q};
  assign accept = (state == IDLE) && layer_start;
  assign load = state == LOAD;
  assign adv = state == ADVANCE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    pass_start = state == ISSUE;
    layer_done = state == DONE;
    busy = state != IDLE;
    case (state)
      IDLE:    state_nx = layer_start ? LOAD : IDLE;
      LOAD:    state_nx = (m_q == '0 || c_q == '0) ? DONE : ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = pass_done ? ADVANCE : WAIT;
      ADVANCE: state_nx = (c_more || m_more) ? ISSUE : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // Layer descriptor snapshot; inputs are free to change once a layer is accepted.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q <= '0;
      map_q <= '0;
      sh1_q <= '0;
      sh2_q <= '0;
      m_q <= '0;
      c_q <= '0;
      fb_q <= '0;
      ib_q <= '0;
      bb_q <= '0;
      ob_q <= '0;
      fs_q <= '0;
      is_q <= '0;
      bs_q <= '0;
      os_q <= '0;
    end else if (accept) begin
      op_q <= layer_op_config[31:1];
      map_q <= layer_mapping_param;
      sh1_q <= layer_shape_param1;
      sh2_q <= layer_shape_param2;
      m_q <= layer_M;
      c_q <= layer_C;
      fb_q <= filter_base;
      ib_q <= ifmap_base;
      bb_q <= bias_base;
      ob_q <= opsum_base;
      fs_q <= filter_pass_stride;
      is_q <= ifmap_cgrp_stride;
      bs_q <= bias_mgrp_stride;
      os_q <= opsum_mgrp_stride;
    end
  // Input-channel groups form the inner loop; wrapping it steps the output-channel group.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m_ct <= '0;
      c_ct <= '0;
      m_acc <= '0;
      c_acc <= '0;
      pass_idx <= '0;
      pass_bias_ipsum_sel <= 1'b0;
    end else if (load) begin
      m_ct <= '0;
      c_ct <= '0;
      m_acc <= '0;
      c_acc <= '0;
      pass_idx <= '0;
      pass_bias_ipsum_sel <= 1'b1;
    end else if (adv) begin
      if (c_more) begin
        c_ct <= c_ct + 1'b1;
        c_acc <= c_acc + {{(CNT_W-5){1'b0}}, qr};
        pass_bias_ipsum_sel <= 1'b0;
      end else if (m_more) begin
        c_ct <= '0;
        c_acc <= '0;
        pass_bias_ipsum_sel <= 1'b1;
        m_ct <= m_ct + 1'b1;
        m_acc <= m_acc + {{(CNT_W-5){1'b0}}, pt};
      end
      if (c_more || m_more) pass_idx <= pass_idx + 1'b1;
    end
  seq_addr_accum #(.ADDR_W(ADDR_W)) u_filter (
    .clk(clk), .rst(rst), .load(load), .step(adv && (c_more || m_more)),
    .base(fb_q), .stride(fs_q), .addr(pass_filter_baseaddr)
  );
  seq_addr_accum #(.ADDR_W(ADDR_W)) u_ifmap (
    .clk(clk), .rst(rst), .load(load || (adv && !c_more && m_more)), .step(adv && c_more),
    .base(ib_q), .stride(is_q), .addr(pass_ifmap_baseaddr)
  );
  seq_addr_accum #(.ADDR_W(ADDR_W)) u_bias (
    .clk(clk), .rst(rst), .load(load), .step(adv && !c_more && m_more),
    .base(bb_q), .stride(bs_q), .addr(pass_bias_baseaddr)
  );
  seq_addr_accum #(.ADDR_W(ADDR_W)) u_opsum (
    .clk(clk), .rst(rst), .load(load), .step(adv && !c_more && m_more),
    .base(ob_q), .stride(os_q), .addr(pass_opsum_baseaddr)
  );
  assign pass_op_config = {op_q, pass_start};
  assign pass_mapping_param = map_q;
  assign pass_shape_param1 = sh1_q;
  assign pass_shape_param2 = sh2_q;
endmodule
